// File: rtl/dsp_comm_pkg.sv
// Shared types for the polyphase output commutator: direction and occupancy
// encodings plus the channel-index width helper.
package dsp_comm_pkg;

   typedef enum logic {
      C_DIR_CW  = 1'b0,
      C_DIR_CCW = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // A single-channel build still needs a 1-bit index.
   function automatic int c_chan_width(input int num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

endpackage

// File: rtl/commutator_stream_if.sv
// Frame-in / sample-out handshake bundle; slave is the commutator side,
// master is the producer/consumer side.
interface commutator_stream_if
   import dsp_comm_pkg::*;
#(
   parameter int gp_idata_width  = 26,
   parameter int gp_num_channels = 32
);
   localparam int CW = c_chan_width(gp_num_channels);

   logic [gp_num_channels*gp_idata_width-1:0] i_data;
   logic                                      i_valid;
   logic                                      o_ready;
   logic                                      i_ccw;
   logic signed [gp_idata_width-1:0]          o_data;
   logic [CW-1:0]                             o_chan;
   logic                                      o_first;
   logic                                      o_last;
   logic                                      o_valid;
   logic                                      i_ready;

   modport slave (
      input  i_data, i_valid, i_ccw, i_ready,
      output o_ready, o_data, o_chan, o_first, o_last, o_valid
   );

   modport master (
      output i_data, i_valid, i_ccw, i_ready,
      input  o_ready, o_data, o_chan, o_first, o_last, o_valid
   );

endinterface

// File: rtl/comm_frame_reg.sv
// Frame register with load enable and synchronous reset to a configurable value.
// One cycle from load to q; no handshake of its own.
module comm_frame_reg #(
   parameter int                  gp_width   = 1,
   parameter logic [gp_width-1:0] gp_rst_val = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [gp_width-1:0] d,
   output logic [gp_width-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= gp_rst_val;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/commutator_stream.sv
// Parallel-to-serial commutator: a frame accepted at edge t shows sample 0 from t;
// two-deep frame buffering keeps output gapless, o_ready drops only while PEND is full.
module commutator_stream
   import dsp_comm_pkg::*;
#(
   parameter int gp_idata_width  = 26,
   parameter int gp_num_channels = 32,
   parameter bit gp_ccw_default  = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   commutator_stream_if.slave bus
);

   localparam int W  = gp_idata_width;
   localparam int N  = gp_num_channels;
   localparam int CW = c_chan_width(N);
   localparam int FW = N * W;
   localparam int RW = FW + 1;

   localparam logic [CW-1:0] IDX_MAX = CW'(N - 1);
   localparam logic [RW-1:0] REG_RST = {gp_ccw_default, {FW{1'b0}}};

   occ_e          occ_q, occ_d;
   logic          rdy_q;
   logic [CW-1:0] idx_q, idx_d;
   logic [RW-1:0] act_q, pend_q, act_d;
   logic          act_ld, pend_ld;
   logic          accept, xfer, last_x;
   logic          act_ccw;

   // The direction bit sits on top of each stored frame.
   assign act_ccw = act_q[FW];

   assign bus.o_ready = rdy_q;
   assign bus.o_valid = (occ_q != OCC_EMPTY);
   assign bus.o_chan  = idx_q;
   assign bus.o_data  = act_q[int'(idx_q)*W +: W];
   assign bus.o_first = bus.o_valid && (idx_q == (act_ccw ? '0 : IDX_MAX));
   assign bus.o_last  = bus.o_valid && (idx_q == (act_ccw ? IDX_MAX : '0));

   assign accept = bus.i_valid && rdy_q;
   assign xfer   = bus.o_valid && bus.i_ready;
   assign last_x = xfer && bus.o_last;

   always_comb begin
      occ_d   = occ_q;
      act_ld  = 1'b0;
      pend_ld = 1'b0;
      act_d   = {bus.i_ccw, bus.i_data};
      unique case (occ_q)
         OCC_EMPTY: begin
            if (accept) begin
               act_ld = 1'b1;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (last_x) begin
               if (accept) begin
                  act_ld = 1'b1;
               end else begin
                  occ_d = OCC_EMPTY;
               end
            end else if (accept) begin
               pend_ld = 1'b1;
               occ_d   = OCC_FULL;
            end
         end
         OCC_FULL: begin
            // o_ready is low here, so only PEND can refill ACTIVE.
            if (last_x) begin
               act_ld = 1'b1;
               act_d  = pend_q;
               occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   always_comb begin
      idx_d = idx_q;
      if (act_ld) begin
         idx_d = act_d[FW] ? '0 : IDX_MAX;
      end else if (xfer && !bus.o_last) begin
         idx_d = act_ccw ? (idx_q + 1'b1) : (idx_q - 1'b1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         occ_q <= OCC_EMPTY;
         rdy_q <= 1'b0;
         idx_q <= '0;
      end else begin
         occ_q <= occ_d;
         rdy_q <= (occ_d != OCC_FULL);
         idx_q <= idx_d;
      end
   end

   comm_frame_reg #(
      .gp_width   (RW),
      .gp_rst_val (REG_RST)
   ) u_active (
      .clk  (i_clk),
      .rst  (i_rst),
      .load (act_ld),
      .d    (act_d),
      .q    (act_q)
   );

   comm_frame_reg #(
      .gp_width   (RW),
      .gp_rst_val (REG_RST)
   ) u_pend (
      .clk  (i_clk),
      .rst  (i_rst),
      .load (pend_ld),
      .d    ({bus.i_ccw, bus.i_data}),
      .q    (pend_q)
   );

endmodule

// File: tb/tb_commutator_stream.sv
// Scoreboard bench: drivers push expected samples on frame accept, monitors pop on transfer.
module tb_commutator_stream;

   logic clk = 1'b0;
   logic i_rst;

   always #5 clk = ~clk;

   commutator_stream_if #(.gp_idata_width(8), .gp_num_channels(4)) bus  ();
   commutator_stream_if #(.gp_idata_width(8), .gp_num_channels(1)) bus1 ();

   commutator_stream #(
      .gp_idata_width(8), .gp_num_channels(4), .gp_ccw_default(1'b1)
   ) u_dut4 (
      .i_clk (clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   commutator_stream #(
      .gp_idata_width(8), .gp_num_channels(1), .gp_ccw_default(1'b1)
   ) u_dut1 (
      .i_clk (clk),
      .i_rst (i_rst),
      .bus   (bus1.slave)
   );

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] ch;
      logic       f;
      logic       l;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];

   int errors = 0;
   int checks = 0;
   int run4, max_run4, run1, max_run1;
   logic saw_full;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endfunction

   task automatic push4(input logic [31:0] d, input logic ccw);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.ch = ccw ? 2'(k) : 2'(3 - k);
         e.d  = d[int'(e.ch)*8 +: 8];
         e.f  = (k == 0);
         e.l  = (k == 3);
         q4.push_back(e);
      end
   endtask

   task automatic send4(input logic [31:0] d, input logic ccw);
      int t = 0;
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_data  = d;
      bus.i_ccw   = ccw;
      while (!bus.o_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("accept4", {31'd0, bus.o_ready}, 32'd1);
      push4(d, ccw);
      @(posedge clk);
   endtask

   task automatic send1(input logic [7:0] d, input logic ccw);
      exp_t e;
      int t = 0;
      @(negedge clk);
      bus1.i_valid = 1'b1;
      bus1.i_data  = d;
      bus1.i_ccw   = ccw;
      while (!bus1.o_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("accept1", {31'd0, bus1.o_ready}, 32'd1);
      e.d = d; e.ch = 2'd0; e.f = 1'b1; e.l = 1'b1;
      q1.push_back(e);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.i_valid  = 1'b0;
      bus1.i_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q4.size() + q1.size()) != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain", q4.size() + q1.size(), 32'd0);
   endtask

   // Monitor for the N=4 instance, including the hold-under-stall check.
   initial begin
      logic [11:0] cur, held;
      logic        held_vld;
      exp_t        e;
      held_vld = 1'b0;
      held     = '0;
      run4     = 0;
      max_run4 = 0;
      saw_full = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         cur = {bus.o_data, bus.o_chan, bus.o_first, bus.o_last};
         if (held_vld) chk("stall_hold", {20'd0, cur}, {20'd0, held});
         held_vld = bus.o_valid && !bus.i_ready && !i_rst;
         held     = cur;
         run4     = bus.o_valid ? run4 + 1 : 0;
         if (run4 > max_run4) max_run4 = run4;
         if (bus.o_valid && !bus.o_ready && !i_rst) saw_full = 1'b1;
         if (bus.o_valid && bus.i_ready && !i_rst) begin
            if (q4.size() == 0) begin
               chk("unexpected4", q4.size(), 32'd1);
            end else begin
               e = q4.pop_front();
               chk("sample4", {20'd0, cur}, {20'd0, e});
            end
         end
      end
   end

   initial begin
      logic [11:0] cur;
      exp_t        e;
      run1     = 0;
      max_run1 = 0;
      forever begin
         @(negedge clk);
         #1;
         cur  = {bus1.o_data, 1'b0, bus1.o_chan, bus1.o_first, bus1.o_last};
         run1 = bus1.o_valid ? run1 + 1 : 0;
         if (run1 > max_run1) max_run1 = run1;
         if (bus1.o_valid && bus1.i_ready && !i_rst) begin
            if (q1.size() == 0) begin
               chk("unexpected1", q1.size(), 32'd1);
            end else begin
               e = q1.pop_front();
               chk("sample1", {20'd0, cur}, {20'd0, e});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst        = 1'b1;
      bus.i_valid  = 1'b0;
      bus.i_data   = '0;
      bus.i_ccw    = 1'b0;
      bus.i_ready  = 1'b1;
      bus1.i_valid = 1'b0;
      bus1.i_data  = '0;
      bus1.i_ccw   = 1'b0;
      bus1.i_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outs4", {20'd0, bus.o_valid, bus.o_ready, bus.o_data, bus.o_chan},  32'd0);
      chk("reset_outs4_fl", {30'd0, bus.o_first, bus.o_last}, 32'd0);
      chk("reset_outs1", {21'd0, bus1.o_valid, bus1.o_ready, bus1.o_data, bus1.o_chan}, 32'd0);
      i_rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst4", {31'd0, bus.o_ready},  32'd1);
      chk("ready_after_rst1", {31'd0, bus1.o_ready}, 32'd1);

      // One CCW frame
      max_run4 = 0;
      send4(32'h44332211, 1'b1);
      idle();
      drain();
      chk("vld_low_t1", {31'd0, bus.o_valid}, 32'd0);
      chk("run_t1", max_run4, 32'd4);

      // Same frame CW
      send4(32'h44332211, 1'b0);
      idle();
      drain();

      // Three frames back-to-back, mixed directions
      max_run4 = 0;
      saw_full = 1'b0;
      send4(32'hA3A2A1A0, 1'b1);
      send4(32'hB3B2B1B0, 1'b0);
      send4(32'hC3C2C1C0, 1'b1);
      idle();
      drain();
      chk("run_t3", max_run4, 32'd12);
      chk("ready_low_seen", {31'd0, saw_full}, 32'd1);

      // Downstream stalls mid-frame
      send4(32'hD3D2D1D0, 1'b1);
      idle();
      bus.i_ready = 1'b0;
      @(negedge clk);
      bus.i_ready = 1'b0;
      @(negedge clk);
      bus.i_ready = 1'b1;
      drain();

      // Reset mid-frame with PEND full
      send4(32'hE3E2E1E0, 1'b1);
      send4(32'hF3F2F1F0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      i_rst       = 1'b1;
      bus.i_valid = 1'b0;
      q4.delete();
      @(negedge clk);
      chk("rst_mid_vld", {31'd0, bus.o_valid}, 32'd0);
      chk("rst_mid_rdy", {31'd0, bus.o_ready}, 32'd0);
      i_rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_rdy_rel", {31'd0, bus.o_ready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("no_stale", {31'd0, bus.o_valid}, 32'd0);
         @(negedge clk);
      end

      // Single-channel build, one frame per cycle
      max_run1 = 0;
      send1(8'h5A, 1'b1);
      send1(8'hA5, 1'b0);
      send1(8'h3C, 1'b1);
      send1(8'hC3, 1'b0);
      idle();
      drain();
      chk("run_n1", max_run1, 32'd4);
      chk("vld_low_n1", {31'd0, bus1.o_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/commutator_stream.md
# commutator_stream

Parallel-to-serial polyphase output commutator with valid/ready handshaking on both sides. It takes one frame of `gp_num_channels` polyphase-branch outputs in parallel and emits them one sample per transfer in a direction chosen per frame (CW or CCW). Frames stream back-to-back with no bubbles. It sits between the polyphase FIR branch array and the downstream sample-rate pipeline of the interpolator. The whole block runs on the single fast clock; there are no derived clocks.

## Interface
- `gp_idata_width`, 26: sample width in bits, signed, minimum 1.
- `gp_num_channels`, 32: channels per frame, minimum 1.
- `gp_ccw_default`, 1: direction loaded by reset into the direction register (1 = CCW, 0 = CW).
- `i_clk` in 1: rising-edge clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_data` in `gp_num_channels*gp_idata_width`: input frame. Channel k occupies bits `[(k+1)*W-1 : k*W]`.
- `i_valid` in 1: input frame valid.
- `o_ready` out 1: block can accept a frame.
- `i_ccw` in 1: direction for the frame being accepted, sampled when the frame is accepted.
- `o_data` out `gp_idata_width`: output sample, signed.
- `o_chan` out `c_chan_width`: channel index of `o_data`.
- `o_first` out 1: `o_data` is the first sample of its frame.
- `o_last` out 1: `o_data` is the last sample of its frame. This replaces the old pulsed slow clock.
- `o_valid` out 1: output sample valid.
- `i_ready` in 1: downstream accepts the sample.

## Operation
- Two frame registers:
  - ACTIVE: the frame being serialized. Holds a direction bit and the current index.
  - PEND: one waiting frame. Holds a direction bit.
- A frame is accepted when `i_valid && o_ready`.
- A sample is transferred when `o_valid && i_ready`.
- Occupancy states:
  - EMPTY: neither register holds a frame.
  - ONE: only ACTIVE holds a frame.
  - FULL: both registers hold a frame.
- `o_ready` equals NOT PEND full, and is 0 while `i_rst` is high. It depends on registered state only.
- Frame accept:
  - If ACTIVE is empty, the frame goes to ACTIVE.
  - If ACTIVE is transferring its last sample in the same cycle, the frame also goes to ACTIVE.
  - Otherwise the frame goes to PEND.
- Completing a frame (last sample transferred):
  - If PEND is full, PEND moves to ACTIVE and PEND becomes empty.
  - If PEND is empty and a frame is accepted in the same cycle, that frame goes to ACTIVE.
  - Otherwise ACTIVE becomes empty.
- Index order:
  - CCW: channel 0, 1, …, N-1.
  - CW: channel N-1, N-2, …, 0.
  - The index advances only on a transfer. It wraps to the start of the new frame when a frame completes.
- Output signals:
  - `o_data` is ACTIVE[`o_chan`].
  - `o_valid` is 1 when ACTIVE is full.
  - `o_first` is 1 when the index is at the start for the frame's direction.
  - `o_last` is 1 when the index is at the end for the frame's direction.
- Stability rule: while `o_valid && !i_ready`, `o_data`, `o_chan`, `o_first` and `o_last` hold stable.
- N = 1: every sample has both `o_first` and `o_last` set, and `o_chan` is 0.
- Direction is fixed per frame. A change on `i_ccw` never affects a frame already held.

## Timing
- Reset values:
  - `o_valid` 0, `o_ready` 0, `o_data` 0, `o_chan` 0, `o_first` 0, `o_last` 0.
  - Both registers empty.
  - Direction register set to `gp_ccw_default`.
  - `o_ready` goes to 1 in the first cycle after `i_rst` deasserts.
- Latency: a frame accepted at edge t into an empty block shows its first sample with `o_valid`=1 from edge t.
- Throughput: with `i_ready` held at 1 and a continuous input, one sample every cycle. A new frame is accepted once every N cycles with no gap between frames.
- Reset mid-frame: both frames are discarded. There is no partial output after reset.
- No combinational path from any input to any output.

## Structure
- Shared package / include `dsp_comm_pkg`:
  - `c_chan_width = max(1, $clog2(gp_num_channels))`.
  - Direction encodings `C_DIR_CW = 0`, `C_DIR_CCW = 1`.
  - Occupancy state encodings EMPTY, ONE, FULL.
- Sub-module `comm_frame_reg`: frame register of width `gp_num_channels*gp_idata_width + 1`, with synchronous reset and load enable. Instantiated twice, for ACTIVE and PEND.
- Top level: occupancy FSM, index counter, output mux.

## Test plan
All scenarios use N = 4, W = 8 unless stated.

1. Reset then one CCW frame {ch3..ch0} = {0x44, 0x33, 0x22, 0x11}, `i_ready` held at 1:
   - `o_data` is 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   - `o_chan` is 0, 1, 2, 3.
   - `o_first` is set on the 0x11 sample and `o_last` on the 0x44 sample.
   - `o_valid` returns to 0 after the 0x44 sample.
2. Same frame with `i_ccw` = 0:
   - Output order is 0x44, 0x33, 0x22, 0x11.
   - `o_chan` is 3, 2, 1, 0.
3. Three frames offered back-to-back, `i_ready` at 1:
   - 12 consecutive valid samples with no bubble.
   - `o_ready` falls to 0 while PEND is full.
4. `i_ready` toggles 1, 0, 0, 1 during a frame:
   - Outputs hold for the two stalled cycles.
   - No sample is lost or duplicated.
5. `i_rst` asserted after the second sample of a frame with PEND full:
   - Next cycle: `o_valid` 0 and `o_ready` 0.
   - After release: `o_ready` 1, and no stale data is emitted.
6. N = 1 build: every sample has `o_first` = `o_last` = 1 and `o_chan` = 0, and the block sustains one frame per cycle.
